// File: rtl/nnrv_exec.sv
// nnrv execute stage: ALU, branch/jump resolution and load/store lane generation, all registered
// into the mem-stage bus, plus ID forwarding view and IF redirect with wrong-path squash.
module nnrv_exec #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_id_valid,
    input  logic [2:0]      i_id_kind,
    input  logic [3:0]      i_id_alu_op,
    input  logic [2:0]      i_id_funct3,
    input  logic            i_id_use_imm,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_rs1_reg,
    input  logic [XLEN-1:0] i_id_rs2_reg,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic            i_id_rd_en,
    input  logic [4:0]      i_id_rd,
    output logic            o_id_rd_en,
    output logic            o_id_rd_ready,
    output logic [4:0]      o_id_rd,
    output logic [XLEN-1:0] o_id_rd_reg,
    output logic            o_mem_rd_en,
    output logic [4:0]      o_mem_rd,
    output logic [XLEN-1:0] o_mem_rd_reg,
    output logic            o_mem_ram_wr_en,
    output logic            o_mem_ram_rd_en,
    output logic [XLEN-1:0] o_mem_ram_addr,
    output logic [XLEN-1:0] o_mem_ram_data,
    output logic [3:0]      o_mem_ram_mask,
    output logic            o_mem_sign,
    output logic            o_if_jump_en,
    output logic [XLEN-1:0] o_if_jump_addr,
    output logic            o_exc_misalign
);

    localparam int unsigned SqW = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

    localparam logic [2:0] KindAlu = 3'd0, KindLoad = 3'd1, KindStore = 3'd2, KindBranch = 3'd3;
    localparam logic [2:0] KindJal = 3'd4, KindJalr = 3'd5, KindLui = 3'd6, KindAuipc = 3'd7;

    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4, AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7;
    localparam logic [3:0] AluOr = 4'd8, AluAnd = 4'd9;

    logic [SqW-1:0]  squash_q, squash_d;
    logic            rd_en_q, rd_en_d, rd_ready_q, rd_ready_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_reg_q, rd_reg_d;
    logic            wr_en_q, wr_en_d, ram_rd_en_q, ram_rd_en_d;
    logic [XLEN-1:0] addr_q, addr_d, data_q, data_d;
    logic [3:0]      mask_q, mask_d;
    logic            sign_q, sign_d, jump_en_q, jump_en_d, misalign_q, misalign_d;
    logic [XLEN-1:0] jump_addr_q, jump_addr_d;

    logic            accept, taken, misaligned;
    logic [XLEN-1:0] op_b, alu_res, ls_addr, st_data;
    logic [4:0]      shamt;
    logic [1:0]      lane, size;
    logic [3:0]      ls_mask;

    always_comb begin
        accept = i_id_valid && (squash_q == '0);
        op_b   = i_id_use_imm ? i_id_imm : i_id_rs2_reg;
        shamt  = op_b[4:0];

        case (i_id_alu_op)
            AluAdd:  alu_res = i_id_rs1_reg + op_b;
            AluSub:  alu_res = i_id_rs1_reg - op_b;
            AluSll:  alu_res = i_id_rs1_reg << shamt;
            AluSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(i_id_rs1_reg) < $signed(op_b)};
            AluSltu: alu_res = {{(XLEN-1){1'b0}}, i_id_rs1_reg < op_b};
            AluXor:  alu_res = i_id_rs1_reg ^ op_b;
            AluSrl:  alu_res = i_id_rs1_reg >> shamt;
            AluSra:  alu_res = $unsigned($signed(i_id_rs1_reg) >>> shamt);
            AluOr:   alu_res = i_id_rs1_reg | op_b;
            AluAnd:  alu_res = i_id_rs1_reg & op_b;
            default: alu_res = '0;
        endcase

        case (i_id_funct3)
            3'd0:    taken = (i_id_rs1_reg == i_id_rs2_reg);
            3'd1:    taken = (i_id_rs1_reg != i_id_rs2_reg);
            3'd4:    taken = $signed(i_id_rs1_reg) < $signed(i_id_rs2_reg);
            3'd5:    taken = !($signed(i_id_rs1_reg) < $signed(i_id_rs2_reg));
            3'd6:    taken = i_id_rs1_reg < i_id_rs2_reg;
            3'd7:    taken = !(i_id_rs1_reg < i_id_rs2_reg);
            default: taken = 1'b0;
        endcase

        ls_addr    = i_id_rs1_reg + i_id_imm;
        lane       = ls_addr[1:0];
        size       = i_id_funct3[1:0];
        misaligned = ((size == 2'd1) && lane[0]) || (size[1] && (lane != 2'd0));
        case (size)
            2'd0:    ls_mask = 4'b0001 << lane;
            2'd1:    ls_mask = 4'b0011 << lane;
            default: ls_mask = 4'b1111;
        endcase
        st_data = size[1] ? i_id_rs2_reg : (i_id_rs2_reg << {lane, 3'b000});
    end

    always_comb begin
        squash_d    = (squash_q != '0) ? squash_q - SqW'(1) : '0;
        rd_en_d     = 1'b0;
        rd_ready_d  = 1'b1;
        rd_d        = '0;
        rd_reg_d    = '0;
        wr_en_d     = 1'b0;
        ram_rd_en_d = 1'b0;
        addr_d      = '0;
        data_d      = '0;
        mask_d      = '0;
        sign_d      = 1'b0;
        jump_en_d   = 1'b0;
        jump_addr_d = '0;
        misalign_d  = 1'b0;
        if (accept) begin
            case (i_id_kind)
                KindAlu, KindLui, KindAuipc: begin
                    rd_en_d  = i_id_rd_en;
                    rd_d     = i_id_rd;
                    rd_reg_d = (i_id_kind == KindAlu) ? alu_res :
                               (i_id_kind == KindLui) ? i_id_imm : i_id_pc + i_id_imm;
                end
                KindJal, KindJalr: begin
                    rd_en_d     = i_id_rd_en;
                    rd_d        = i_id_rd;
                    rd_reg_d    = i_id_pc + XLEN'(4);
                    jump_en_d   = 1'b1;
                    jump_addr_d = (i_id_kind == KindJal) ? i_id_pc + i_id_imm :
                                  (i_id_rs1_reg + i_id_imm) & ~XLEN'(1);
                    squash_d    = SqW'(SQUASH_CYCLES);
                end
                KindBranch: begin
                    if (taken) begin
                        jump_en_d   = 1'b1;
                        jump_addr_d = i_id_pc + i_id_imm;
                        squash_d    = SqW'(SQUASH_CYCLES);
                    end
                end
                KindLoad, KindStore: begin
                    addr_d = ls_addr;
                    mask_d = ls_mask;
                    if (i_id_kind == KindStore) data_d = st_data;
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else if (i_id_kind == KindStore) begin
                        wr_en_d = 1'b1;
                    end else begin
                        ram_rd_en_d = 1'b1;
                        rd_en_d     = i_id_rd_en;
                        rd_d        = i_id_rd;
                        sign_d      = ~i_id_funct3[2];
                        rd_ready_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            squash_q    <= '0;
            rd_en_q     <= 1'b0;
            rd_ready_q  <= 1'b0;
            rd_q        <= '0;
            rd_reg_q    <= '0;
            wr_en_q     <= 1'b0;
            ram_rd_en_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            sign_q      <= 1'b0;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            squash_q    <= squash_d;
            rd_en_q     <= rd_en_d;
            rd_ready_q  <= rd_ready_d;
            rd_q        <= rd_d;
            rd_reg_q    <= rd_reg_d;
            wr_en_q     <= wr_en_d;
            ram_rd_en_q <= ram_rd_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            sign_q      <= sign_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
            misalign_q  <= misalign_d;
        end
    end

    assign o_mem_rd_en     = rd_en_q;
    assign o_mem_rd        = rd_q;
    assign o_mem_rd_reg    = rd_reg_q;
    assign o_id_rd_en      = rd_en_q;
    assign o_id_rd         = rd_q;
    assign o_id_rd_reg     = rd_reg_q;
    assign o_id_rd_ready   = rd_ready_q;
    assign o_mem_ram_wr_en = wr_en_q;
    assign o_mem_ram_rd_en = ram_rd_en_q;
    assign o_mem_ram_addr  = addr_q;
    assign o_mem_ram_data  = data_q;
    assign o_mem_ram_mask  = mask_q;
    assign o_mem_sign      = sign_q;
    assign o_if_jump_en    = jump_en_q;
    assign o_if_jump_addr  = jump_addr_q;
    assign o_exc_misalign  = misalign_q;

endmodule
